// File: rtl/cramer_seq.sv
// Sequential Cramer's-rule solver: drives a shared determinant engine once for the
// base matrix and once per column, then streams each unknown as a num/den pair.
module cramer_seq #(
    parameter int unsigned SIZE = 3,
    parameter int unsigned CW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 singular,
    output logic                 det_req,
    output logic [CW-1:0]        det_col,
    input  logic                 det_ack,
    input  logic signed [31:0]   det_value,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CW-1:0]        res_idx,
    output logic signed [31:0]   res_num,
    output logic signed [31:0]   res_den
);

    localparam logic [CW-1:0] BaseCol = CW'(SIZE);
    localparam logic [CW-1:0] LastIdx = CW'(SIZE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StBase,
        StChk,
        StCol,
        StEmit,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      g_q, g_d;
    logic signed [31:0] d_q, d_d;
    logic               flip_q, flip_d;
    logic               singular_q, singular_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic signed [31:0] num_q, num_d;
    logic signed [31:0] den_q, den_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            g_q        <= '0;
            d_q        <= '0;
            flip_q     <= 1'b0;
            singular_q <= 1'b0;
            idx_q      <= '0;
            num_q      <= '0;
            den_q      <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            d_q        <= d_d;
            flip_q     <= flip_d;
            singular_q <= singular_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            den_q      <= den_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        d_d        = d_q;
        flip_d     = flip_q;
        singular_d = singular_q;
        idx_d      = idx_q;
        num_d      = num_q;
        den_d      = den_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StBase;
                    singular_d = 1'b0;
                    g_d        = '0;
                end
            end
            StBase: begin
                if (det_ack) begin
                    d_d     = det_value;
                    state_d = StChk;
                end
            end
            StChk: begin
                if (d_q == 32'sd0) begin
                    singular_d = 1'b1;
                    state_d    = StFin;
                end else begin
                    // Fold the base sign into the numerators so the denominator stays positive.
                    flip_d  = d_q[31];
                    den_d   = d_q[31] ? -d_q : d_q;
                    state_d = StCol;
                end
            end
            StCol: begin
                if (det_ack) begin
                    num_d   = flip_q ? -det_value : det_value;
                    idx_d   = g_q;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (res_ready) begin
                    if (g_q == LastIdx) begin
                        state_d = StFin;
                    end else begin
                        g_d     = g_q + 1'b1;
                        state_d = StCol;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        det_req   = (state_q == StBase) || (state_q == StCol);
        res_valid = (state_q == StEmit);
        det_col   = '0;
        if (state_q == StBase) begin
            det_col = BaseCol;
        end else if (state_q == StCol) begin
            det_col = g_q;
        end
    end

    assign singular = singular_q;
    assign res_idx  = idx_q;
    assign res_num  = num_q;
    assign res_den  = den_q;

endmodule

// File: tb/tb_cramer_seq.sv
// Bench for cramer_seq: table of solves against a behavioural determinant engine,
// results checked through a scoreboard queue, plus a reset-abort sequence.
module tb_cramer_seq;

    localparam int SIZE = 3;
    localparam int CW   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy, done, singular, det_req, det_ack, res_valid, res_ready;
    logic [CW-1:0]       det_col, res_idx;
    logic signed [31:0]  det_value, res_num, res_den;

    cramer_seq #(.SIZE(SIZE), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .singular  (singular),
        .det_req   (det_req),
        .det_col   (det_col),
        .det_ack   (det_ack),
        .det_value (det_value),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_num   (res_num),
        .res_den   (res_den)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Determinant engine model
    int  base_det;
    int  col_det[SIZE];
    int  ack_delay;
    int  wait_cnt;
    bit  ack_force;

    always @(posedge clk) begin
        if (rst || !det_req || det_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    always @* begin
        det_ack   = (det_req && (wait_cnt == ack_delay)) || ack_force;
        det_value = 32'sd99;
        if (det_req) begin
            if (int'(det_col) == SIZE) det_value = base_det;
            else if (int'(det_col) < SIZE) det_value = col_det[det_col];
        end
    end

    typedef struct {
        int idx;
        int num;
        int den;
    } res_t;
    res_t sb_q[$];

    int done_cnt;
    int xact_cnt;
    bit prev_req, prev_ack, prev_valid, prev_ready;
    logic [CW-1:0] prev_col, prev_idx;
    logic signed [31:0] prev_num, prev_den;

    // Negedge monitor: scoreboard pops, handshake stability, event counts
    always @(negedge clk) begin
        if (rst) begin
            prev_req   = 1'b0;
            prev_ack   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (det_req && det_ack) xact_cnt++;
            if (prev_req && !prev_ack) begin
                check("det_req_held", det_req, 1);
                check("det_col_stable", det_col, prev_col);
            end
            if (prev_valid && !prev_ready) begin
                check("res_valid_held", res_valid, 1);
                check("res_idx_stable", res_idx, prev_idx);
                check("res_num_stable", res_num, prev_num);
                check("res_den_stable", res_den, prev_den);
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    check("res_idx", res_idx, e.idx);
                    check("res_num", res_num, e.num);
                    check("res_den", res_den, e.den);
                end
            end
            prev_req   = det_req;
            prev_ack   = det_ack;
            prev_col   = det_col;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_idx   = res_idx;
            prev_num   = res_num;
            prev_den   = res_den;
        end
    end

    typedef struct {
        int base;
        int c0, c1, c2;
        int n0, n1, n2;
        int den;
        bit sing;
        int dly;
        int stall_idx;
        int stall_len;
        bit start_emit;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic load_engine(input vec_t v);
        base_det  = v.base;
        col_det[0] = v.c0;
        col_det[1] = v.c1;
        col_det[2] = v.c2;
        ack_delay = v.dly;
    endtask

    task automatic push_expected(input vec_t v);
        res_t r;
        if (!v.sing) begin
            r.idx = 0; r.num = v.n0; r.den = v.den; sb_q.push_back(r);
            r.idx = 1; r.num = v.n1; r.den = v.den; sb_q.push_back(r);
            r.idx = 2; r.num = v.n2; r.den = v.den; sb_q.push_back(r);
        end
    endtask

    task automatic run_solve(input vec_t v);
        int  cyc;
        int  rem;
        int  done_cyc;
        bit  got_done;
        bit  pulsed;
        load_engine(v);
        push_expected(v);
        done_cnt = 0;
        xact_cnt = 0;
        rem      = v.stall_len;
        got_done = 0;
        pulsed   = 0;
        done_cyc = -1;
        cyc      = 0;
        @(negedge clk);
        start     = 1'b1;
        res_ready = 1'b1;
        while (!got_done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (v.start_emit && !pulsed && res_valid) begin
                start  = 1'b1;
                pulsed = 1;
            end
            res_ready = 1'b1;
            if (res_valid && int'(res_idx) == v.stall_idx && rem > 0) begin
                res_ready = 1'b0;
                rem--;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        check("done_latency", done_cyc, v.exp_done);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_pulses", done_cnt, 1);
        check("results_left", sb_q.size(), 0);
        check("det_transactions", xact_cnt, v.sing ? 1 : SIZE + 1);
        check("singular", singular, v.sing);
        check("busy_after", busy, 0);
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_singular"}, singular, 0);
        check({tag, "_det_req"}, det_req, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_det_col"}, det_col, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_res_num"}, res_num, 0);
        check({tag, "_res_den"}, res_den, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int imin;
        bit found;
        imin = 32'h8000_0000;
        //        base c0    c1  c2   n0    n1  n2   den sing dly stl len emit done
        vecs[0] = '{-1,  -2,   -3, 1,   2,    3,  -1,  1,  0,   0, -1, 0,  0,   9};
        vecs[1] = '{0,   5,    6,  7,   0,    0,  0,   0,  1,   0, -1, 0,  0,   3};
        vecs[2] = '{4,   8,    -2, 6,   8,    -2, 6,   4,  0,   0, 1,  5,  0,   14};
        vecs[3] = '{-1,  -2,   -3, 1,   2,    3,  -1,  1,  0,   3, -1, 0,  0,   21};
        vecs[4] = '{-6,  12,   -6, 18,  -12,  6,  -18, 6,  0,   0, -1, 0,  1,   9};
        vecs[5] = '{-1,  imin, 5,  -7,  imin, -5, 7,   1,  0,   0, -1, 0,  0,   9};
        vecs[6] = '{7,   -14,  0,  21,  -14,  0,  21,  7,  0,   0, -1, 0,  0,   9};

        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        ack_force = 1'b0;
        ack_delay = 0;
        base_det  = 0;
        for (int i = 0; i < SIZE; i++) col_det[i] = 0;
        done_cnt  = 0;
        xact_cnt  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_solve(vecs[i]);

        // Abort in COL with g=1, then a stray ack after release
        load_engine(vecs[0]);
        ack_delay = 10;
        push_expected(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (det_req && det_col == 1) found = 1;
        end
        check("reach_col1", found, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_force = 1'b1;
        done_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("stray_ack");
        ack_force = 1'b0;
        check("abort_no_done", done_cnt, 0);

        run_solve(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cramer_seq.md
CRAMER_SEQ -- requirements
Module: cramer_seq

Interface
REQ-001 SHALL have parameter SIZE, default 3: order of the square system; legal range is 2..7.
REQ-002 SHALL have parameter CW, default 3: width of column and index fields; CW >= ceil(log2(SIZE+1)).
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: requests one solve; sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-007 SHALL have port done, output, 1: one-cycle pulse at the end of every solve.
REQ-008 SHALL have port singular, output, 1: base determinant was zero; level output.
REQ-009 SHALL have port det_req, output, 1: request to the shared determinant engine.
REQ-010 SHALL have port det_col, output, CW: column replaced by the RHS vector; value SIZE selects the unmodified base matrix.
REQ-011 SHALL have port det_ack, input, 1: engine completion strobe.
REQ-012 SHALL have port det_value, input, 32 signed: determinant; valid only when det_ack is high.
REQ-013 SHALL have port res_valid, output, 1: result available.
REQ-014 SHALL have port res_ready, input, 1: downstream formatter accepts the result.
REQ-015 SHALL have port res_idx, output, CW: index of the unknown.
REQ-016 SHALL have ports res_num and res_den, output, 32 signed each: unknown = res_num / res_den, with res_den > 0.

Function
REQ-017 SHALL implement states IDLE, BASE, CHK, COL, EMIT, FIN.
REQ-018 IDLE: start=1 SHALL go to BASE, clear singular, and set g=0; start=0 SHALL stay in IDLE.
REQ-019 BASE: det_req=1 with det_col=SIZE; on det_ack SHALL capture det_value into D and go to CHK.
REQ-020 CHK, D==0: SHALL set singular=1 and go to FIN without issuing any column request or result.
REQ-021 CHK, D!=0: SHALL set flip=(D<0), set res_den=|D|, and go to COL.
REQ-022 COL: det_req=1 with det_col=g; on det_ack SHALL load res_num = flip ? -det_value : det_value, set res_idx=g, and go to EMIT.
REQ-023 EMIT: res_valid=1; on res_valid&&res_ready SHALL go to FIN if g==SIZE-1, else increment g and go to COL.
REQ-024 FIN: done=1 for exactly one cycle, then IDLE.
REQ-025 det_req handshake: det_req SHALL be high for the whole BASE/COL wait and drop in the cycle after the ack edge.
REQ-026 det_col SHALL be stable while det_req is high.
REQ-027 det_ack while det_req is low SHALL be ignored.
REQ-028 Zero-wait engine (ack in the same cycle as req) SHALL be legal.
REQ-029 res_idx, res_num and res_den SHALL be stable while res_valid && !res_ready.
REQ-030 res_valid SHALL drop in the cycle after the handshake.
REQ-031 Latency: start accepted at edge 0 -> det_req high after edge 0.
REQ-032 Latency, zero-wait engine and res_ready=1: done SHALL pulse 3+2*SIZE cycles after start.
REQ-033 Negation SHALL be 32-bit two's complement; -2^31 wraps to itself and is not flagged.
REQ-034 start while busy SHALL be ignored and SHALL have no effect on the solve in progress.
REQ-035 singular SHALL hold until the next accepted start or reset.

Reset
REQ-036 rst SHALL force IDLE immediately and asynchronously: busy, done, singular, det_req, res_valid=0; det_col, res_idx, res_num, res_den=0; g=0; D=0; flip=0.
REQ-037 Reset mid-operation SHALL abandon the solve; a pending det_ack after reset SHALL be ignored; no done pulse.

Verification
REQ-038 Engine model holds A=[[2,1,-1],[-3,-1,2],[-2,1,2]], b=[8,-11,-3]; returns D=-1 and col determinants -2,-3,1 -> results (0,2,1),(1,3,1),(2,-1,1); singular=0; one done pulse.
REQ-039 Base det_value=0 -> singular=1, no res_valid, done pulses; exactly one det_req transaction.
REQ-040 D=4, cols 8,-2,6; res_ready low for 5 cycles at idx 1 -> res_valid held with outputs stable; results (0,8,4),(1,-2,4),(2,6,4).
REQ-041 det_ack delayed 3 cycles on each request -> det_req/det_col stable throughout; correct results; done at 3+2*SIZE+12 cycles.
REQ-042 rst asserted while waiting in COL (g=1), late det_ack applied after release -> all outputs 0, IDLE, ack ignored; a new start then solves correctly.
REQ-043 start pulsed during EMIT -> ignored; exactly SIZE results and one done pulse.
